// File: rtl/tube_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tube_frame_arbiter
// Brief   : Round-robin sharing of the seven-segment tube between two frame
//           requesters; each frame becomes held writes to addresses 0, 2, 4.
// Revision: 1.0 - initial release
// ============================================================================
module tube_frame_arbiter #(
   parameter int HOLD_CYCLES    = 64,
   parameter bit SKIP_UNCHANGED = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_low,
   input  logic [15:0] req0_high,
   input  logic [15:0] req0_special,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_low,
   input  logic [15:0] req1_high,
   input  logic [15:0] req1_special,
   output logic        req1_ready,
   output logic        tube_ctrl,
   output logic        tube_write_enable,
   output logic [2:0]  tube_address,
   output logic [15:0] tube_write_data,
   output logic        busy,
   output logic        grant_id
);

   localparam int                 c_cnt_w     = $clog2(HOLD_CYCLES);
   localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

   generate
      if (HOLD_CYCLES < 53) begin : g_hold_check
         $error("HOLD_CYCLES must cover one 52-clock refresh period plus margin (>= 53)");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_W_LOW  = 3'd2,
      S_W_HIGH = 3'd3,
      S_W_SPEC = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_last_grant;
   logic [15:0]        r_low, r_high, r_spec;
   logic [15:0]        r_sh_low, r_sh_high, r_sh_spec;
   logic [c_cnt_w-1:0] r_cnt;

   logic   w_skip_low, w_skip_high, w_skip_spec;
   logic   w_any_valid, w_pick1, w_cnt_done;
   state_t w_after_load, w_after_low, w_after_high;

   // A skipped phase takes zero cycles, so successor selection jumps over it.
   assign w_skip_low   = SKIP_UNCHANGED && (r_low  == r_sh_low);
   assign w_skip_high  = SKIP_UNCHANGED && (r_high == r_sh_high);
   assign w_skip_spec  = SKIP_UNCHANGED && (r_spec == r_sh_spec);
   assign w_after_high = !w_skip_spec ? S_W_SPEC : S_GAP;
   assign w_after_low  = !w_skip_high ? S_W_HIGH : w_after_high;
   assign w_after_load = !w_skip_low  ? S_W_LOW  : w_after_low;

   assign w_any_valid = req0_valid | req1_valid;
   assign w_pick1     = req1_valid && (!req0_valid || !r_last_grant);
   assign w_cnt_done  = (r_cnt == '0);
   assign busy        = (r_state != S_IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_valid) w_next = S_LOAD;
         S_LOAD:   w_next = w_after_load;
         S_W_LOW:  if (w_cnt_done) w_next = w_after_low;
         S_W_HIGH: if (w_cnt_done) w_next = w_after_high;
         S_W_SPEC: if (w_cnt_done) w_next = S_GAP;
         S_GAP:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state           <= S_IDLE;
         r_last_grant      <= 1'b1;
         r_low             <= '0;
         r_high            <= '0;
         r_spec            <= '0;
         r_sh_low          <= '0;
         r_sh_high         <= '0;
         r_sh_spec         <= '0;
         r_cnt             <= '0;
         req0_ready        <= 1'b0;
         req1_ready        <= 1'b0;
         grant_id          <= 1'b0;
         tube_ctrl         <= 1'b0;
         tube_write_enable <= 1'b0;
         tube_address      <= 3'd0;
         tube_write_data   <= 16'd0;
      end else begin
         r_state    <= w_next;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;

         if (r_state == S_IDLE && w_any_valid) begin
            grant_id     <= w_pick1;
            r_last_grant <= w_pick1;
            req0_ready   <= !w_pick1;
            req1_ready   <= w_pick1;
            r_low        <= w_pick1 ? req1_low     : req0_low;
            r_high       <= w_pick1 ? req1_high    : req0_high;
            r_spec       <= w_pick1 ? req1_special : req0_special;
         end

         if (w_next != r_state &&
             (w_next == S_W_LOW || w_next == S_W_HIGH || w_next == S_W_SPEC))
            r_cnt <= c_hold_last;
         else if (!w_cnt_done)
            r_cnt <= r_cnt - 1'b1;

         if (w_cnt_done) begin
            if (r_state == S_W_LOW)  r_sh_low  <= r_low;
            if (r_state == S_W_HIGH) r_sh_high <= r_high;
            if (r_state == S_W_SPEC) r_sh_spec <= r_spec;
         end

         // Tube outputs are registered from the state being entered.
         tube_ctrl         <= 1'b0;
         tube_write_enable <= 1'b0;
         tube_address      <= 3'd0;
         tube_write_data   <= 16'd0;
         case (w_next)
            S_W_LOW: begin
               tube_ctrl         <= 1'b1;
               tube_write_enable <= 1'b1;
               tube_address      <= 3'd0;
               tube_write_data   <= r_low;
            end
            S_W_HIGH: begin
               tube_ctrl         <= 1'b1;
               tube_write_enable <= 1'b1;
               tube_address      <= 3'd2;
               tube_write_data   <= r_high;
            end
            S_W_SPEC: begin
               tube_ctrl         <= 1'b1;
               tube_write_enable <= 1'b1;
               tube_address      <= 3'd4;
               tube_write_data   <= r_spec;
            end
            S_GAP:   tube_ctrl <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tube_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tube_frame_arbiter
// Brief   : Directed table, corner sequences and random traffic against a
//           frame-schedule reference model of tube_frame_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tube_frame_arbiter;

   localparam int c_hold = 64;
   localparam bit c_skip = 1'b1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_low = '0, req0_high = '0, req0_special = '0;
   logic [15:0] req1_low = '0, req1_high = '0, req1_special = '0;
   logic        req0_ready, req1_ready, tube_ctrl, tube_write_enable, busy, grant_id;
   logic [2:0]  tube_address;
   logic [15:0] tube_write_data;

   tube_frame_arbiter #(.HOLD_CYCLES(c_hold), .SKIP_UNCHANGED(c_skip)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_low(req0_low), .req0_high(req0_high),
      .req0_special(req0_special), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_low(req1_low), .req1_high(req1_high),
      .req1_special(req1_special), .req1_ready(req1_ready),
      .tube_ctrl(tube_ctrl), .tube_write_enable(tube_write_enable),
      .tube_address(tube_address), .tube_write_data(tube_write_data),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        r0, r1, busy, gid, ctrl, we;
      logic [2:0]  addr;
      logic [15:0] data;
   } outs_t;

   typedef struct {
      logic        port;
      logic [15:0] lo, hi, sp;
      logic [2:0]  mask;
      int          busy_cycles;
   } vec_t;

   // Reference model: on each grant the whole remaining output trace is queued.
   outs_t       sched[$];
   logic [15:0] m_sh[3];
   logic        m_last;
   outs_t       act;
   int checks = 0, failures = 0, nprint = 0;

   task automatic chk(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic build(input logic w);
      logic [15:0] wd[3];
      outs_t e;
      wd = w ? '{req1_low, req1_high, req1_special} : '{req0_low, req0_high, req0_special};
      e = '0; e.r0 = !w; e.r1 = w; e.busy = 1'b1; e.gid = w;
      sched.push_back(e);
      for (int i = 0; i < 3; i++) begin
         if (!(c_skip && wd[i] == m_sh[i])) begin
            e = '0; e.busy = 1'b1; e.gid = w; e.ctrl = 1'b1; e.we = 1'b1;
            e.addr = 3'(2 * i); e.data = wd[i];
            repeat (c_hold) sched.push_back(e);
            m_sh[i] = wd[i];
         end
      end
      e = '0; e.busy = 1'b1; e.gid = w; e.ctrl = 1'b1;
      sched.push_back(e);
      sched.push_back('0);
      m_last = w;
   endtask

   task automatic tick();
      outs_t e;
      e = '0;
      if (reset) begin
         sched.delete();
         m_sh = '{16'd0, 16'd0, 16'd0};
         m_last = 1'b1;
      end else if (sched.size() != 0) begin
         e = sched.pop_front();
      end else if (req0_valid || req1_valid) begin
         build(req1_valid && (!req0_valid || !m_last));
         e = sched.pop_front();
      end
      @(posedge clock);
      #1;
      act = '{req0_ready, req1_ready, busy, grant_id, tube_ctrl, tube_write_enable,
              tube_address, tube_write_data};
      if (!e.busy) act.gid = 1'b0;
      checks++;
      if (act != e) begin
         failures++;
         if (nprint < 30) begin
            nprint++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
         end
      end
   endtask

   task automatic set_req(input logic port, input logic v, input logic [15:0] lo, hi, sp);
      if (port) begin
         req1_valid = v; req1_low = lo; req1_high = hi; req1_special = sp;
      end else begin
         req0_valid = v; req0_low = lo; req0_high = hi; req0_special = sp;
      end
   endtask

   task automatic drop(input logic port);
      if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic run_frame(input logic port, input logic [15:0] lo, hi, sp,
                            output logic [2:0] mask, output int bcnt, output int rlat);
      bit seen, done;
      mask = '0; bcnt = 0; rlat = -1; seen = 0; done = 0;
      set_req(port, 1'b1, lo, hi, sp);
      for (int i = 1; i <= 400 && !done; i++) begin
         tick();
         if (port ? act.r1 : act.r0) begin rlat = i; drop(port); end
         if (act.we) mask[act.addr[2:1]] = 1'b1;
         if (act.busy) begin bcnt++; seen = 1; end
         else if (seen) done = 1;
      end
      drop(port);
      chk("frame_completes", int'(done), 1);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 3))
         0:       return 16'h0000;
         1:       return 16'h1234;
         2:       return 16'hFF00;
         default: return 16'($urandom);
      endcase
   endfunction

   vec_t vecs[4];

   initial begin
      logic [2:0] mask;
      int bcnt, rlat, t_idle, t_r1, n_r1, n_we;
      bit done;

      vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'hFF00, 3'b111, 194};
      vecs[1] = '{1'b0, 16'h1234, 16'h5678, 16'hFF00, 3'b000, 2};
      vecs[2] = '{1'b0, 16'h1234, 16'h0ABC, 16'hFF00, 3'b010, 66};
      vecs[3] = '{1'b1, 16'h1234, 16'h0ABC, 16'hFF00, 3'b000, 2};

      m_last = 1'b1;
      m_sh = '{16'd0, 16'd0, 16'd0};
      do_reset();
      chk("reset_busy", int'(busy), 0);
      chk("reset_tube_address", int'(tube_address), 0);
      chk("reset_write_enable", int'(tube_write_enable), 0);

      foreach (vecs[k]) begin
         run_frame(vecs[k].port, vecs[k].lo, vecs[k].hi, vecs[k].sp, mask, bcnt, rlat);
         chk($sformatf("vec%0d_write_mask", k), int'(mask), int'(vecs[k].mask));
         chk($sformatf("vec%0d_busy_cycles", k), bcnt, vecs[k].busy_cycles);
         chk($sformatf("vec%0d_ready_latency", k), rlat, 1);
         tick();
      end

      // Tie after reset: req0 first, req1 one cycle after the return to IDLE.
      do_reset();
      set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
      set_req(1'b1, 1'b1, 16'h4444, 16'h5555, 16'h6666);
      t_idle = -1; t_r1 = -1; done = 0;
      for (int i = 1; i <= 400 && !done; i++) begin
         tick();
         if (i == 1) chk("tie_first_ready0", int'(act.r0), 1);
         if (act.r0) req0_valid = 1'b0;
         if (!act.busy && i > 1 && t_idle < 0) t_idle = i;
         if (act.r1) begin t_r1 = i; req1_valid = 1'b0; done = 1; end
      end
      chk("tie_second_grant_cycle", t_r1, t_idle + 1);
      done = 0;
      for (int i = 1; i <= 400 && !done; i++) begin
         tick();
         done = !act.busy;
      end
      set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
      set_req(1'b1, 1'b1, 16'h4444, 16'h5555, 16'h6666);
      tick();
      chk("tie_again_ready0", int'(act.r0), 1);
      chk("tie_again_ready1", int'(act.r1), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Reset in the middle of W_HIGH discards the frame and clears shadows.
      do_reset();
      set_req(1'b0, 1'b1, 16'h1234, 16'h5678, 16'hFF00);
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (act.r0) req0_valid = 1'b0;
      end
      chk("midframe_addr", int'(act.addr), 2);
      do_reset();
      chk("midframe_reset_busy", int'(busy), 0);
      chk("midframe_reset_ctrl", int'(tube_ctrl), 0);
      run_frame(1'b0, 16'h1234, 16'h5678, 16'hFF00, mask, bcnt, rlat);
      chk("after_reset_write_mask", int'(mask), 3'b111);
      chk("after_reset_busy_cycles", bcnt, 194);

      // req1 raised and withdrawn while busy is never granted.
      tick();
      set_req(1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0003);
      n_r1 = 0; done = 0;
      for (int i = 1; i <= 400 && !done; i++) begin
         tick();
         if (act.r0) req0_valid = 1'b0;
         req1_valid = (i >= 10 && i < 15);
         if (act.r1) n_r1++;
         done = (i > 1) && !act.busy;
      end
      req1_valid = 1'b0;
      n_we = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (act.busy || act.we || act.r1) n_we++;
      end
      chk("withdraw_no_ready1", n_r1, 0);
      chk("withdraw_quiet", n_we, 0);

      // Random traffic; handshakes follow the valid/hold-until-ready rule.
      for (int c = 0; c < 12000; c++) begin
         reset = ($urandom_range(0, 2999) == 0);
         tick();
         for (int p = 0; p < 2; p++) begin
            if (p == 0 ? act.r0 : act.r1) drop(1'(p));
            else if (!(p == 0 ? req0_valid : req1_valid)) begin
               if ($urandom_range(0, 15) == 0) set_req(1'(p), 1'b1, pick(), pick(), pick());
            end else if ($urandom_range(0, 99) == 0) drop(1'(p));
         end
      end
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         done = !act.busy;
      end
      chk("drain_idle", int'(done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
